// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Width of a counter that can hold the values 0..width.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// Purely combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & (y | bi)) | (y & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin, LSB first; result valid WIDTH cycles after accept, held until out_ready.
// One operation in flight, inputs ignored outside IDLE; SERIAL_SUB_SAT_EN clamps underflow to 0.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  sub_state_e         state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cell_d;
  logic               cell_bo;
  logic               last_bit;
  logic [WIDTH:0]     diff_cat;
  logic [WIDTH-1:0]   diff_d;

  fs_cell u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  assign diff_cat = {cell_d, diff_q};
  assign diff_d   = diff_cat[WIDTH:1];
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            diff_q   <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          borrow_q <= cell_bo;
          cnt_q    <= cnt_q + CNT_W'(1);
`ifdef SERIAL_SUB_SAT_EN
          if (last_bit && cell_bo) begin
            diff_q <= '0;
          end else begin
            diff_q <= diff_d;
          end
`else
          diff_q   <= diff_d;
`endif
          if (last_bit) begin
            bout_q  <= cell_bo;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances, directed table, corner sequences, random ops.
module tb_serial_sub_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, bout8, busy8;
  logic [7:0] diff8;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, out_valid1, bout1, busy1;
  logic [0:0] diff1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .busy(busy8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow = result went negative.
  function automatic void model(input int w, input longint unsigned av, input longint unsigned bv,
                                input int bi, output longint unsigned d, output bit bo);
    longint r;
    r  = longint'(av) - longint'(bv) - longint'(bi);
    bo = (r < 0);
    d  = longint'(r) & ((64'd1 << w) - 64'd1);
`ifdef SERIAL_SUB_SAT_EN
    if (bo) d = 0;
`endif
  endfunction

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     input logic [7:0] ed, input logic eb, input int stall, input string nm);
    int g;
    int lat;
    g = 0;
    while (!in_ready8 && g < 50) begin @(negedge clk); g++; end
    chk({nm, ".in_ready"}, in_ready8, 1);
    a8 = av; b8 = bv; bin8 = bi; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = ~av; b8 = ~bv; bin8 = ~bi;
    chk({nm, ".busy"}, busy8, 1);
    lat = 0;
    while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
    chk({nm, ".latency"}, lat, 8);
    repeat (stall) @(negedge clk);
    chk({nm, ".out_valid"}, out_valid8, 1);
    chk({nm, ".diff"}, diff8, ed);
    chk({nm, ".bout"}, bout8, eb);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk({nm, ".drained"}, {out_valid8, in_ready8}, 2'b01);
  endtask

  task automatic op1(input logic av, input logic bv, input logic bi,
                     input logic ed, input logic eb, input string nm);
    int g;
    int lat;
    g = 0;
    while (!in_ready1 && g < 50) begin @(negedge clk); g++; end
    a1 = av; b1 = bv; bin1 = bi; in_valid1 = 1'b1; out_ready1 = 1'b0;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 100) begin @(negedge clk); lat++; end
    chk({nm, ".latency"}, lat, 1);
    chk({nm, ".diff_bout"}, {diff1, bout1}, {ed, eb});
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk({nm, ".drained"}, {out_valid1, in_ready1}, 2'b01);
  endtask

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  initial begin
    vec_t vecs[12];
    longint unsigned md;
    bit mbo;
    int lat;
    logic [7:0] ra, rb;
    logic rbi;

    vecs[0] = '{8, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
`ifdef SERIAL_SUB_SAT_EN
    vecs[1] = '{8, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1};
`else
    vecs[1] = '{8, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
`endif
    vecs[3] = '{8, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    // WIDTH=1 full-subtractor truth table {a,b,bin} -> {d,bo}
    vecs[4]  = '{1, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0};
    vecs[5]  = '{1, 8'h0, 8'h0, 1'b1, 8'h1, 1'b1};
    vecs[6]  = '{1, 8'h0, 8'h1, 1'b0, 8'h1, 1'b1};
    vecs[7]  = '{1, 8'h0, 8'h1, 1'b1, 8'h0, 1'b1};
    vecs[8]  = '{1, 8'h1, 8'h0, 1'b0, 8'h1, 1'b0};
    vecs[9]  = '{1, 8'h1, 8'h0, 1'b1, 8'h0, 1'b0};
    vecs[10] = '{1, 8'h1, 8'h1, 1'b0, 8'h0, 1'b0};
    vecs[11] = '{1, 8'h1, 8'h1, 1'b1, 8'h1, 1'b1};
`ifdef SERIAL_SUB_SAT_EN
    for (int i = 4; i < 12; i++) if (vecs[i].bo) vecs[i].d = 8'h0;
`endif

    #12;
    chk("reset.hold", {in_ready8, out_valid8, busy8, diff8, bout8}, {3'b100, 8'h00, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.dut8", {in_ready8, out_valid8, busy8, diff8, bout8}, {3'b100, 8'h00, 1'b0});
    chk("reset.dut1", {in_ready1, out_valid1, busy1, diff1, bout1}, 5'b10000);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].w == 8)
        op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, 0, $sformatf("vec%0d", i));
      else
        op1(vecs[i].a[0], vecs[i].b[0], vecs[i].bin, vecs[i].d[0], vecs[i].bo, $sformatf("vec%0d", i));
    end

    // Stall in DONE while in_valid is asserted throughout RUN and DONE.
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(negedge clk); lat++;
    end
    chk("stall.latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      chk($sformatf("stall.hold%0d", i), {out_valid8, in_ready8, diff8, bout8}, {2'b10, 8'h22, 1'b0});
    end
    a8 = 8'h40; b8 = 8'h04; bin8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("stall.idle_first", {out_valid8, in_ready8, busy8}, 3'b010);
    @(negedge clk);
    in_valid8 = 1'b0;
    chk("stall.next_taken", busy8, 1);
    lat = 0;
    while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
    chk("stall.next_diff", {diff8, bout8}, {8'h3C, 1'b0});
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;

    // Asynchronous reset in the middle of RUN.
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.state", {in_ready8, out_valid8, busy8, diff8, bout8}, {3'b100, 8'h00, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0, "rst_mid.fresh");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      if (i % 4 == 0) rb = ra;
      model(8, ra, rb, rbi, md, mbo);
      op8(ra, rb, rbi, md[7:0], mbo, $urandom_range(0, 3), $sformatf("rnd8_%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 1)); rb = 8'($urandom_range(0, 1)); rbi = 1'($urandom);
      model(1, ra, rb, rbi, md, mbo);
      op1(ra[0], rb[0], rbi, md[0], mbo, $sformatf("rnd1_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
